// File: rtl/lcd_hex_display_ctrl_if.sv
// HD44780-style 8-bit write bus between the sequencer (master) and the LCD pins (slave).
interface lcd_hex_display_ctrl_if;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (output lcd_db, lcd_rs, lcd_rw, lcd_en);
  modport slave  (input  lcd_db, lcd_rs, lcd_rw, lcd_en);
endinterface

// File: rtl/lcd_hex_display_ctrl.sv
// Character-LCD sequencer: 1 us divider, init commands, 40 hex-to-ASCII data writes and home,
// with E-pulse/settle timing; refresh requests replay the display pass without re-initialising.
module lcd_hex_display_ctrl #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int POWERUP_US   = 20000,
  parameter int CMD_WAIT_US  = 40,
  parameter int CLR_WAIT_US  = 1640
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          refresh,
  input  logic [3:0]                    data_in,
  output logic                          one_us_clk,
  output logic [5:0]                    lcd_cmd_ptr,
  output logic                          busy,
  output logic                          init_done,
  lcd_hex_display_ctrl_if.master        lcd
);

  localparam int HALF   = CLK_FREQ_MHZ / 2;
  localparam int DIV_W  = $clog2(HALF + 1);
  localparam int MAX_US = (POWERUP_US > CLR_WAIT_US)
                          ? ((POWERUP_US > CMD_WAIT_US) ? POWERUP_US : CMD_WAIT_US)
                          : ((CLR_WAIT_US > CMD_WAIT_US) ? CLR_WAIT_US : CMD_WAIT_US);
  localparam int CNT_W  = $clog2(MAX_US + 1);

  localparam logic [5:0] PTR_FIRST_DATA = 6'h04;
  localparam logic [5:0] PTR_LAST_DATA  = 6'h2B;
  localparam logic [5:0] PTR_CLEAR      = 6'h03;
  localparam logic [5:0] PTR_HOME       = 6'h2C;
  localparam logic [5:0] PTR_END        = 6'h2D;
  localparam logic [5:0] PTR_REFRESH    = 6'h02;

  typedef enum logic [2:0] {
    POWERUP,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             tick;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx, wait_last;
  logic [5:0]       ptr_nx;
  logic [5:0]       ptr_inc;
  logic             refresh_pend;
  logic             pend_clr;
  logic             is_data;
  logic             is_slow;
  logic [7:0]       db_q, db_nx;
  logic             rs_q, rs_nx;

  // tick marks the clk cycle on which one_us_clk rises
  assign div_wrap = (div_cnt == DIV_W'(HALF - 1));
  assign tick     = div_wrap & ~one_us_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      one_us_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt    <= '0;
      one_us_clk <= ~one_us_clk;
    end else begin
      div_cnt    <= div_cnt + DIV_W'(1);
    end
  end

  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign is_data   = (lcd_cmd_ptr >= PTR_FIRST_DATA) && (lcd_cmd_ptr <= PTR_LAST_DATA);
  assign is_slow   = (lcd_cmd_ptr == PTR_CLEAR) || (lcd_cmd_ptr == PTR_HOME);
  assign wait_last = is_slow ? CNT_W'(CLR_WAIT_US - 1) : CNT_W'(CMD_WAIT_US - 1);
  assign ptr_inc   = lcd_cmd_ptr + 6'd1;

  always_comb begin
    rs_nx = 1'b0;
    db_nx = 8'h00;
    if (is_data) begin
      rs_nx = 1'b1;
      db_nx = nibble_ascii(data_in);
    end else begin
      case (lcd_cmd_ptr)
        6'h00:     db_nx = 8'h38;
        6'h01:     db_nx = 8'h06;
        6'h02:     db_nx = 8'h0C;
        PTR_CLEAR: db_nx = 8'h01;
        PTR_HOME:  db_nx = 8'h02;
        default:   db_nx = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    ptr_nx      = lcd_cmd_ptr;
    pend_clr    = 1'b0;
    if (tick) begin
      case (state)
        POWERUP: begin
          if (wait_cnt == CNT_W'(POWERUP_US - 1)) begin
            wait_cnt_nx = '0;
            state_nx    = SETUP;
          end else begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
          end
        end
        SETUP:   state_nx = EN_HI;
        EN_HI:   state_nx = HOLD;
        HOLD:    state_nx = WAIT;
        WAIT: begin
          if (wait_cnt == wait_last) begin
            wait_cnt_nx = '0;
            ptr_nx      = ptr_inc;
            state_nx    = (ptr_inc == PTR_END) ? IDLE : SETUP;
          end else begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (refresh || refresh_pend) begin
            ptr_nx   = PTR_REFRESH;
            pend_clr = 1'b1;
            state_nx = SETUP;
          end
        end
        default: state_nx = POWERUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= POWERUP;
      wait_cnt     <= '0;
      lcd_cmd_ptr  <= 6'h00;
      refresh_pend <= 1'b0;
      init_done    <= 1'b0;
      db_q         <= 8'h00;
      rs_q         <= 1'b0;
    end else begin
      state        <= state_nx;
      wait_cnt     <= wait_cnt_nx;
      lcd_cmd_ptr  <= ptr_nx;
      refresh_pend <= pend_clr ? 1'b0 : (refresh_pend | refresh);
      init_done    <= init_done | (state_nx == IDLE);
      // data bytes keep following data_in while E is high so the converter latency is absorbed
      if (state == SETUP || (state == EN_HI && is_data)) begin
        db_q <= db_nx;
        rs_q <= rs_nx;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign lcd.lcd_en = (state == EN_HI);
  assign lcd.lcd_db = db_q;
  assign lcd.lcd_rs = rs_q;
  assign lcd.lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_hex_display_ctrl.sv
// Directed bench for lcd_hex_display_ctrl: logs every E rise and checks bytes, timing and pass control.
module tb_lcd_hex_display_ctrl;
  localparam int CLK_FREQ_MHZ = 4;
  localparam int POWERUP_US   = 10;
  localparam int CMD_WAIT_US  = 4;
  localparam int CLR_WAIT_US  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refresh = 1'b0;
  logic [3:0] data_in;
  logic       one_us_clk;
  logic [5:0] lcd_cmd_ptr;
  logic       busy;
  logic       init_done;

  lcd_hex_display_ctrl_if lcd ();

  lcd_hex_display_ctrl #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
    .POWERUP_US  (POWERUP_US),
    .CMD_WAIT_US (CMD_WAIT_US),
    .CLR_WAIT_US (CLR_WAIT_US)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .refresh    (refresh),
    .data_in    (data_in),
    .one_us_clk (one_us_clk),
    .lcd_cmd_ptr(lcd_cmd_ptr),
    .busy       (busy),
    .init_done  (init_done),
    .lcd        (lcd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // nibble source: 0x1, 0xA, 0xF, 0x0 repeating with the pointer
  always_comb begin
    case (lcd_cmd_ptr[1:0])
      2'd0:    data_in = 4'h1;
      2'd1:    data_in = 4'hA;
      2'd2:    data_in = 4'hF;
      default: data_in = 4'h0;
    endcase
  end

  logic [7:0] exp_chr [4] = '{8'h31, 8'h41, 8'h46, 8'h30};
  logic [7:0] exp_cmd [4] = '{8'h38, 8'h06, 8'h0C, 8'h01};

  logic [7:0] wr_db  [$];
  logic       wr_rs  [$];
  int         wr_cyc [$];
  logic [5:0] wr_ptr [$];
  int         busy_rises = 0;
  int         busy_fall_cyc = 0;
  logic       en_q = 1'b0;
  logic       busy_q = 1'b1;

  always @(negedge clk) begin
    if (lcd.lcd_en && !en_q) begin
      wr_db.push_back(lcd.lcd_db);
      wr_rs.push_back(lcd.lcd_rs);
      wr_cyc.push_back(cyc);
      wr_ptr.push_back(lcd_cmd_ptr);
    end
    if (busy && !busy_q) busy_rises = busy_rises + 1;
    if (!busy && busy_q) busy_fall_cyc = cyc;
    en_q   = lcd.lcd_en;
    busy_q = busy;
  end

  task automatic clear_log();
    wr_db.delete();
    wr_rs.delete();
    wr_cyc.delete();
    wr_ptr.delete();
    busy_rises = 0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int r1, r2;
    logic prev;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (lcd_cmd_ptr !== 6'h00) begin
      errors++; $display("FAIL reset_ptr: got %h required 00", lcd_cmd_ptr);
    end
    checks++;
    if ({lcd.lcd_db, lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_en} !== 11'h000) begin
      errors++; $display("FAIL reset_bus: db=%h rs=%b rw=%b en=%b required all 0",
                         lcd.lcd_db, lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_en);
    end
    checks++;
    if ({one_us_clk, busy, init_done} !== 3'b010) begin
      errors++; $display("FAIL reset_status: one_us_clk/busy/init_done=%b required 010",
                         {one_us_clk, busy, init_done});
    end
    clear_log();
    reset = 1'b0;
    rel_cyc = cyc;
    r1 = -1;
    r2 = -1;
    prev = one_us_clk;
    for (int i = 0; i < 20 && r2 < 0; i++) begin
      @(negedge clk);
      if (one_us_clk && !prev) begin
        if (r1 < 0) r1 = cyc;
        else r2 = cyc;
      end
      prev = one_us_clk;
    end
    checks++;
    if (r1 - rel_cyc != 2) begin
      errors++; $display("FAIL first_us_rise: got %0d clk after release required 2", r1 - rel_cyc);
    end
    checks++;
    if (r2 < 0 || r2 - r1 != 4) begin
      errors++; $display("FAIL us_period: got %0d clk required 4", r2 - r1);
    end
  endtask

  task automatic test_powerup_timing();
    for (int i = 0; i < 200 && wr_db.size() == 0; i++) @(negedge clk);
    checks++;
    if (wr_db.size() == 0) begin
      errors++; $display("FAIL powerup_en_timeout: no E pulse within 200 clk");
      return;
    end
    checks++;
    if (wr_cyc[0] - rel_cyc != 42) begin
      errors++; $display("FAIL powerup_en_time: got %0d clk required 42", wr_cyc[0] - rel_cyc);
    end
    checks++;
    if ({wr_ptr[0], wr_rs[0], wr_db[0]} !== {6'h00, 1'b0, 8'h38}) begin
      errors++; $display("FAIL first_write: ptr=%h rs=%b db=%h required ptr=00 rs=0 db=38",
                         wr_ptr[0], wr_rs[0], wr_db[0]);
    end
  endtask

  task automatic test_first_pass();
    wait_idle("first_pass");
    checks++;
    if (wr_db.size() != 45) begin
      errors++; $display("FAIL pass_writes: got %0d required 45", wr_db.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_rs[i], wr_db[i]} !== {1'b0, exp_cmd[i]}) begin
        errors++; $display("FAIL init_cmd[%0d]: rs=%b db=%h required rs=0 db=%h",
                           i, wr_rs[i], wr_db[i], exp_cmd[i]);
      end
    end
    for (int i = 4; i < 44; i++) begin
      checks++;
      if ({wr_rs[i], wr_db[i]} !== {1'b1, exp_chr[i % 4]}) begin
        errors++; $display("FAIL data_chr[%0d]: rs=%b db=%h required rs=1 db=%h",
                           i, wr_rs[i], wr_db[i], exp_chr[i % 4]);
      end
    end
    checks++;
    if ({wr_rs[44], wr_db[44]} !== {1'b0, 8'h02}) begin
      errors++; $display("FAIL home_cmd: rs=%b db=%h required rs=0 db=02", wr_rs[44], wr_db[44]);
    end
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (wr_cyc[i+1] - wr_cyc[i] != ((i == 3) ? 44 : 28)) begin
        errors++; $display("FAIL en_gap[%0d]: got %0d clk required %0d",
                           i, wr_cyc[i+1] - wr_cyc[i], (i == 3) ? 44 : 28);
      end
    end
    checks++;
    if (busy_fall_cyc - wr_cyc[44] != 40) begin
      errors++; $display("FAIL home_settle: got %0d clk required 40", busy_fall_cyc - wr_cyc[44]);
    end
    checks++;
    if ({lcd_cmd_ptr, busy, init_done} !== {6'h2D, 1'b0, 1'b1}) begin
      errors++; $display("FAIL pass_end: ptr=%h busy=%b init_done=%b required 2d 0 1",
                         lcd_cmd_ptr, busy, init_done);
    end
  endtask

  task automatic test_refresh_idle();
    int n;
    int bad;
    clear_log();
    pulse_refresh();
    n = 0;
    for (int i = 0; i < 8 && lcd_cmd_ptr != 6'h02; i++) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lcd_cmd_ptr !== 6'h02 || n > 4 || busy !== 1'b1) begin
      errors++; $display("FAIL refresh_start: ptr=%h after %0d clk busy=%b required 02 within 4 busy=1",
                         lcd_cmd_ptr, n, busy);
    end
    wait_idle("refresh");
    checks++;
    if (wr_db.size() != 43) begin
      errors++; $display("FAIL refresh_writes: got %0d required 43", wr_db.size());
      return;
    end
    checks++;
    if ({wr_db[0], wr_db[1], wr_db[42]} !== 24'h0C0102) begin
      errors++; $display("FAIL refresh_cmds: got %h %h %h required 0c 01 02",
                         wr_db[0], wr_db[1], wr_db[42]);
    end
    bad = 0;
    for (int i = 0; i < 43; i++)
      if (!wr_rs[i] && (wr_db[i] == 8'h38 || wr_db[i] == 8'h06)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL refresh_no_init: got %0d init writes required 0", bad);
    end
    for (int i = 2; i < 42; i++) begin
      checks++;
      if ({wr_rs[i], wr_db[i]} !== {1'b1, exp_chr[(i + 2) % 4]}) begin
        errors++; $display("FAIL refresh_chr[%0d]: rs=%b db=%h required rs=1 db=%h",
                           i, wr_rs[i], wr_db[i], exp_chr[(i + 2) % 4]);
      end
    end
    checks++;
    if (wr_cyc[2] - wr_cyc[1] != 44) begin
      errors++; $display("FAIL refresh_clr_gap: got %0d clk required 44", wr_cyc[2] - wr_cyc[1]);
    end
    checks++;
    if ({lcd_cmd_ptr, init_done} !== {6'h2D, 1'b1}) begin
      errors++; $display("FAIL refresh_end: ptr=%h init_done=%b required 2d 1", lcd_cmd_ptr, init_done);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_refresh();
    for (int i = 0; i < 8 && !busy; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    pulse_refresh();
    repeat (300) @(negedge clk);
    pulse_refresh();
    wait_idle("b2b_pass1");
    for (int i = 0; i < 12 && !busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_extra_pass: busy=%b required 1", busy);
    end
    wait_idle("b2b_pass2");
    repeat (400) @(negedge clk);
    checks++;
    if (busy_rises != 2) begin
      errors++; $display("FAIL b2b_pass_count: got %0d passes required 2", busy_rises);
    end
    checks++;
    if (wr_db.size() != 86) begin
      errors++; $display("FAIL b2b_writes: got %0d required 86", wr_db.size());
    end else begin
      checks++;
      if (wr_db[43] !== 8'h0C) begin
        errors++; $display("FAIL b2b_second_start: got %h required 0c", wr_db[43]);
      end
    end
    checks++;
    if ({busy, lcd_cmd_ptr} !== {1'b0, 6'h2D}) begin
      errors++; $display("FAIL b2b_idle: busy=%b ptr=%h required 0 2d", busy, lcd_cmd_ptr);
    end
  endtask

  task automatic test_reset_midop();
    pulse_refresh();
    for (int i = 0; i < 200 && !lcd.lcd_en; i++) @(negedge clk);
    checks++;
    if (lcd.lcd_en !== 1'b1) begin
      errors++; $display("FAIL midop_en_timeout: en=%b required 1", lcd.lcd_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (lcd.lcd_en !== 1'b0) begin
      errors++; $display("FAIL midop_async_en: got %b required 0", lcd.lcd_en);
    end
    @(negedge clk);
    checks++;
    if ({lcd_cmd_ptr, busy, init_done} !== {6'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midop_reset_state: ptr=%h busy=%b init_done=%b required 00 1 0",
                         lcd_cmd_ptr, busy, init_done);
    end
    clear_log();
    reset = 1'b0;
    rel_cyc = cyc;
    for (int i = 0; i < 200 && wr_db.size() == 0; i++) @(negedge clk);
    checks++;
    if (wr_db.size() == 0) begin
      errors++; $display("FAIL midop_restart_timeout: no E pulse within 200 clk");
      return;
    end
    checks++;
    if (wr_cyc[0] - rel_cyc != 42 || {wr_ptr[0], wr_db[0]} !== {6'h00, 8'h38}) begin
      errors++; $display("FAIL midop_restart: at %0d clk ptr=%h db=%h required 42 clk ptr=00 db=38",
                         wr_cyc[0] - rel_cyc, wr_ptr[0], wr_db[0]);
    end
  endtask

  initial begin
    test_reset();
    test_powerup_timing();
    test_first_pass();
    test_refresh_idle();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
